// File: rtl/queue_port_arbiter_if.sv
// queue_port_arbiter_if: requester-side handshake bundle between producers/consumer and the arbiter
interface queue_port_arbiter_if #(
    parameter int N  = 8,
    parameter int CW = 11
);
    logic [1:0]    wr_req;
    logic [N-1:0]  wr_data0;
    logic [N-1:0]  wr_data1;
    logic [1:0]    wr_ack;
    logic          rd_req;
    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    modport master (output wr_req, wr_data0, wr_data1, rd_req, input wr_ack, rd_data, rd_valid, count);
    modport slave  (input wr_req, wr_data0, wr_data1, rd_req, output wr_ack, rd_data, rd_valid, count);
endinterface

// File: rtl/queue_port_arbiter.sv
// queue_port_arbiter: sequences two writers and one reader onto a single-port bidirectional queue bus
module queue_port_arbiter #(
    parameter int N         = 8,
    parameter int DEPTH     = 1024,
    parameter int MAX_BURST = 4,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int BW       = $clog2(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             reset,
    queue_port_arbiter_if.slave req,
    inout  wire  [N-1:0]     io_q,
    output logic             o_q_en,
    output logic             o_q_rw,
    input  logic             i_q_empty,
    input  logic             i_q_full
);
    typedef enum logic [1:0] {IDLE, WR, RD, TA} state_t;
    state_t        r_state, w_state;
    logic          r_dir, w_dir, r_rr, w_rr;
    logic [BW-1:0] r_burst, w_burst;
    logic [1:0]    r_ack, w_ack, w_req;
    logic [N-1:0]  r_wdata, w_wdata, r_rd_data;
    logic          r_rd_valid;
    logic [CW-1:0] r_count, w_count_next;
    logic          w_wel, w_rel, w_cur, w_oth, w_gnt;
    // Eligibility looks at occupancy after the access committing at this same edge
    always_comb begin
        w_count_next = r_count + CW'(r_state == WR) - CW'(r_state == RD);
        w_req        = req.wr_req & ~r_ack;
        w_wel        = (|w_req) && (w_count_next < CW'(DEPTH)) && !i_q_full;
        w_rel        = req.rd_req && (w_count_next != '0) && !i_q_empty;
        w_cur        = r_dir ? w_wel : w_rel;
        w_oth        = r_dir ? w_rel : w_wel;
        w_gnt        = (&w_req) ? r_rr : w_req[1];
        w_state      = IDLE;
        w_dir        = r_dir;
        w_burst      = r_burst;
        w_rr         = r_rr;
        w_ack        = 2'b00;
        w_wdata      = r_wdata;
        if (w_cur && (r_burst < BW'(MAX_BURST) || !w_oth)) begin
            w_state = r_dir ? WR : RD;
            w_burst = (r_burst == BW'(MAX_BURST)) ? r_burst : r_burst + BW'(1);
            if (r_dir) begin
                w_ack   = w_gnt ? 2'b10 : 2'b01;
                w_wdata = w_gnt ? req.wr_data1 : req.wr_data0;
                w_rr    = !w_gnt;
            end
        end else if (w_oth) begin
            w_state = TA;
            w_dir   = !r_dir;
            w_burst = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dir      <= 1'b0;
            r_rr       <= 1'b0;
            r_burst    <= '0;
            r_ack      <= 2'b00;
            r_wdata    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state;
            r_dir      <= w_dir;
            r_rr       <= w_rr;
            r_burst    <= w_burst;
            r_ack      <= w_ack;
            r_wdata    <= w_wdata;
            r_rd_valid <= (r_state == RD);
            r_count    <= w_count_next;
            if (r_state == RD) r_rd_data <= io_q;
        end
    end
    assign o_q_en       = (r_state == WR) || (r_state == RD);
    assign o_q_rw       = r_dir;
    assign io_q         = (r_state == WR) ? r_wdata : {N{1'bz}};
    assign req.wr_ack   = r_ack;
    assign req.rd_data  = r_rd_data;
    assign req.rd_valid = r_rd_valid;
    assign req.count    = r_count;
endmodule

// File: tb/tb_queue_port_arbiter.sv
// tb_queue_port_arbiter: scoreboard bench with a behavioural queue on the shared bus
module tb_queue_port_arbiter;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int MB    = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    queue_port_arbiter_if #(.N(N), .CW(CW)) bus();
    wire  [N-1:0] q_io;
    logic         q_en, q_rw, m_empty, m_full;
    logic [N-1:0] mem [DEPTH];
    int           mcount = 0, head = 0, tail = 0;
    assign m_empty = (mcount == 0);
    assign m_full  = (mcount == DEPTH);
    assign q_io    = (q_en && !q_rw) ? mem[head] : {N{1'bz}};
    always @(posedge clk) begin
        if (reset) begin
            mcount <= 0;
            head   <= 0;
            tail   <= 0;
        end else if (q_en && q_rw && mcount < DEPTH) begin
            mem[tail] <= q_io;
            tail      <= (tail + 1) % DEPTH;
            mcount    <= mcount + 1;
        end else if (q_en && !q_rw && mcount > 0) begin
            head   <= (head + 1) % DEPTH;
            mcount <= mcount - 1;
        end
    end
    queue_port_arbiter #(.N(N), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(bus), .io_q(q_io),
        .o_q_en(q_en), .o_q_rw(q_rw), .i_q_empty(m_empty), .i_q_full(m_full)
    );
    int           errs = 0, checks = 0, cyc = 0, nrd = 0;
    logic [N-1:0] step0 = 0, step1 = 0;
    logic [N-1:0] exp_q [$];
    int           ack_ids [$];
    int           ack_cyc [$];
    byte          ops [$];
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // One clock: observe the cycle just started, push written words, pop and compare read words
    task automatic tick();
        byte c;
        @(posedge clk);
        #1;
        cyc++;
        if (!reset) begin
            c = q_en ? (q_rw ? "W" : "R") : (q_rw ? "w" : "r");
            ops.push_back(c);
            chk("ack_onehot", 32'(bus.wr_ack == 2'b11), 0);
            chk("count", 32'(bus.count), 32'(mcount));
            if (q_en && q_rw) chk("wr_room", 32'(mcount < DEPTH), 1);
            if (q_en && !q_rw) chk("rd_avail", 32'(mcount > 0), 1);
            if (bus.wr_ack[0]) begin
                exp_q.push_back(bus.wr_data0);
                ack_ids.push_back(0);
                ack_cyc.push_back(cyc);
                bus.wr_data0 = bus.wr_data0 + step0;
            end
            if (bus.wr_ack[1]) begin
                exp_q.push_back(bus.wr_data1);
                ack_ids.push_back(1);
                ack_cyc.push_back(cyc);
                bus.wr_data1 = bus.wr_data1 + step1;
            end
            if (bus.rd_valid) begin
                nrd++;
                if (exp_q.size() == 0) chk("rd_extra", 1, 0);
                else chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
        end
    endtask
    task automatic reset_dut();
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        ack_ids.delete();
        ack_cyc.delete();
        ops.delete();
        nrd = 0;
    endtask
    task automatic run_acks(input int n, input int budget);
        for (int i = 0; i < budget && ack_ids.size() < n; i++) tick();
        chk("ack_total", ack_ids.size(), n);
    endtask
    task automatic run_reads(input int n, input int budget);
        for (int i = 0; i < budget && nrd < n; i++) tick();
        chk("rd_total", nrd, n);
    endtask
    string exp_ops = "wWWWWrRRRRwWWWWrRRRRw";
    initial begin
        bus.wr_req   = 2'b00;
        bus.rd_req   = 1'b0;
        bus.wr_data0 = '0;
        bus.wr_data1 = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_q_en", 32'(q_en), 0);
        chk("rst_q_rw", 32'(q_rw), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_wr_ack", 32'(bus.wr_ack), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        // reset asserted while a write is on the bus must not commit it
        bus.wr_data0 = 8'h33;
        bus.wr_req   = 2'b01;
        for (int i = 0; i < 10 && !(q_en && q_rw); i++) tick();
        chk("midwr_seen", 32'(q_en && q_rw), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.wr_req = 2'b00;
        tick();
        chk("midwr_count", 32'(bus.count), 0);
        chk("midwr_q_en", 32'(q_en), 0);
        // single writer fills the queue, then the reader drains it
        reset_dut();
        step0 = 8'd5;
        bus.wr_data0 = 8'd5;
        bus.wr_req = 2'b01;
        run_acks(8, 40);
        for (int i = 1; i < ack_cyc.size(); i++) chk("ack_gap", ack_cyc[i] - ack_cyc[i-1], 2);
        repeat (6) tick();
        chk("full_no_ack", ack_ids.size(), 8);
        chk("full_count", 32'(bus.count), 8);
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b1;
        tick();
        chk("ta_q_en", 32'(q_en), 0);
        chk("ta_q_rw", 32'(q_rw), 0);
        tick();
        chk("rd_q_en", 32'(q_en), 1);
        chk("rd_q_rw", 32'(q_rw), 0);
        run_reads(8, 40);
        repeat (4) tick();
        chk("no_ninth", nrd, 8);
        chk("drain_count", 32'(bus.count), 0);
        chk("sb_empty", exp_q.size(), 0);
        // two writers alternate; last write fills the queue as a new request arrives
        reset_dut();
        step0 = 8'd1;
        step1 = 8'd1;
        bus.wr_data0 = 8'hA0;
        bus.wr_data1 = 8'hB0;
        bus.wr_req = 2'b11;
        run_acks(8, 40);
        for (int i = 0; i < ack_ids.size(); i++) chk("rr_grant", ack_ids[i], i % 2);
        repeat (4) tick();
        chk("rr_full_no_ack", ack_ids.size(), 8);
        chk("rr_full_count", 32'(bus.count), 8);
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b1;
        run_reads(8, 40);
        repeat (3) tick();
        chk("rr_no_ninth", nrd, 8);
        // both directions saturated: bursts of MAX_BURST separated by one turnaround
        reset_dut();
        bus.wr_req = 2'b11;
        bus.rd_req = 1'b1;
        repeat (exp_ops.len()) tick();
        for (int i = 0; i < exp_ops.len(); i++) chk("burst_op", 32'(ops[i]), 32'(exp_ops[i]));
        bus.wr_req = 2'b00;
        bus.rd_req = 1'b0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
